alu_issue_queue: RTL and testbench



---
 rtl/lc3b_pkg.sv | 34 +++
 rtl/alu_issue_decode.sv | 48 ++++
 rtl/alu_issue_queue.sv | 117 +++++++++++
 tb/tb_alu_issue_queue.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_pkg.sv
// Shared LC-3b encodings and the issue-queue entry layout.
// Combinational definitions only: no latency and no backpressure apply here.
package lc3b_pkg;

  localparam int DW   = 16;
  localparam int REGW = 3;
  localparam int OPCW = 4;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_AND   = 2'b01,
    ALU_XOR   = 2'b10,
    ALU_PASSA = 2'b11
  } alu_op_e;

  localparam logic [OPCW-1:0] OP_ADD = 4'b0001;
  localparam logic [OPCW-1:0] OP_AND = 4'b0101;
  localparam logic [OPCW-1:0] OP_XOR = 4'b1001;
  localparam logic [OPCW-1:0] OP_LEA = 4'b1110;

  typedef struct packed {
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    alu_op_e         op;
    logic [REGW-1:0] dr;
    logic            wr_en;
    logic            setcc;
    logic            uses1;
    logic            uses2;
    logic [REGW-1:0] src1;
    logic [REGW-1:0] src2;
  } entry_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Decodes one LC-3b instruction into an issue-queue entry.
// Purely combinational (zero latency) and never stalls.
module alu_issue_decode
  import lc3b_pkg::*;
(
  input  logic [DW-1:0] i_ir,
  input  logic [DW-1:0] i_npc,
  input  logic [DW-1:0] i_sr1,
  input  logic [DW-1:0] i_sr2,
  output entry_t        o_entry
);

  logic [DW-1:0] w_imm5;
  logic [DW-1:0] w_off9x2;

  assign w_imm5   = {{11{i_ir[4]}}, i_ir[4:0]};
  assign w_off9x2 = {{6{i_ir[8]}}, i_ir[8:0], 1'b0};

  always_comb begin
    o_entry       = '0;
    o_entry.dr    = i_ir[11:9];
    o_entry.src1  = i_ir[8:6];
    o_entry.src2  = i_ir[2:0];
    o_entry.op    = ALU_PASSA;
    case (i_ir[15:12])
      OP_ADD, OP_AND, OP_XOR: begin
        o_entry.op    = (i_ir[15:12] == OP_ADD) ? ALU_ADD :
                        (i_ir[15:12] == OP_AND) ? ALU_AND : ALU_XOR;
        o_entry.a     = i_sr1;
        o_entry.b     = i_ir[5] ? w_imm5 : i_sr2;
        o_entry.wr_en = 1'b1;
        o_entry.setcc = 1'b1;
        o_entry.uses1 = 1'b1;
        o_entry.uses2 = ~i_ir[5];
      end
      OP_LEA: begin
        o_entry.a     = i_npc + w_off9x2;
        o_entry.wr_en = 1'b1;
      end
      default: begin
        // Unknown opcodes pass SR1 through so the ALU still sees a defined value.
        o_entry.a     = i_sr1;
        o_entry.uses1 = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Issue queue feeding the ALU: decode, writeback bypass and a DEPTH-entry FIFO.
// Accept-to-out_valid is 1 cycle; in_ready = not full, independent of out_ready.
module alu_issue_queue
  import lc3b_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_ir,
  input  logic [DW-1:0] in_npc,
  input  logic [DW-1:0] in_sr1_data,
  input  logic [DW-1:0] in_sr2_data,
  input  logic          wb_en,
  input  logic [2:0]    wb_reg,
  input  logic [DW-1:0] wb_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [1:0]    out_op,
  output logic [2:0]    out_dr,
  output logic          out_wr_en,
  output logic          out_setcc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          r_mem [DEPTH];
  entry_t          w_mem_nxt [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [DEPTH-1:0] w_vld;
  entry_t          w_dec;
  entry_t          w_cap;
  entry_t          w_head;
  logic            w_push;
  logic            w_pop;

  alu_issue_decode u_decode (
    .i_ir    (in_ir),
    .i_npc   (in_npc),
    .i_sr1   (in_sr1_data),
    .i_sr2   (in_sr2_data),
    .o_entry (w_dec)
  );

  assign in_ready  = (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Same-cycle writeback wins over the regfile read that raced it.
  always_comb begin
    w_cap = w_dec;
    if (wb_en && w_dec.uses1 && (w_dec.src1 == wb_reg)) w_cap.a = wb_data;
    if (wb_en && w_dec.uses2 && (w_dec.src2 == wb_reg)) w_cap.b = wb_data;
  end

  always_comb begin
    w_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_vld[i] = ({1'b0, AW'(i) - r_rd_ptr} < r_count);
    end
  end

  // Held entries, including the visible head, track writebacks in place.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_mem_nxt[i] = r_mem[i];
      if (w_vld[i] && wb_en) begin
        if (r_mem[i].uses1 && (r_mem[i].src1 == wb_reg)) w_mem_nxt[i].a = wb_data;
        if (r_mem[i].uses2 && (r_mem[i].src2 == wb_reg)) w_mem_nxt[i].b = wb_data;
      end
    end
    if (w_push && !flush) w_mem_nxt[r_wr_ptr] = w_cap;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= w_mem_nxt[i];
      if (flush) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign out_a     = w_head.a;
  assign out_b     = w_head.b;
  assign out_op    = w_head.op;
  assign out_dr    = w_head.dr;
  assign out_wr_en = w_head.wr_en;
  assign out_setcc = w_head.setcc;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed checks of alu_issue_queue: decode, ordering, backpressure, bypass, flush, reset.
module tb_alu_issue_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_ir;
  logic [15:0] in_npc;
  logic [15:0] in_sr1_data;
  logic [15:0] in_sr2_data;
  logic        wb_en;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic [1:0]  out_op;
  logic [2:0]  out_dr;
  logic        out_wr_en;
  logic        out_setcc;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(2), .DW(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ir       (in_ir),
    .in_npc      (in_npc),
    .in_sr1_data (in_sr1_data),
    .in_sr2_data (in_sr2_data),
    .wb_en       (wb_en),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_op      (out_op),
    .out_dr      (out_dr),
    .out_wr_en   (out_wr_en),
    .out_setcc   (out_setcc)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] ir, input logic [15:0] s1,
                       input logic [15:0] s2);
    in_valid    = v;
    in_ir       = ir;
    in_sr1_data = s1;
    in_sr2_data = s2;
  endtask

  task automatic chk_head(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] op, input logic [2:0] dr, input logic we,
                          input logic cc);
    chk({tag, ".vld"},   {15'd0, out_valid}, 16'd1);
    chk({tag, ".a"},     out_a, a);
    chk({tag, ".b"},     out_b, b);
    chk({tag, ".op"},    {14'd0, out_op}, {14'd0, op});
    chk({tag, ".dr"},    {13'd0, out_dr}, {13'd0, dr});
    chk({tag, ".wr"},    {15'd0, out_wr_en}, {15'd0, we});
    chk({tag, ".cc"},    {15'd0, out_setcc}, {15'd0, cc});
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    wb_en = 1'b0; wb_reg = 3'd0; wb_data = 16'h0; in_npc = 16'h3000;
    drive(1'b1, 16'h1283, 16'h0005, 16'h0007);
    tick(); tick();
    chk("rst.vld", {15'd0, out_valid}, 16'd0);
    chk("rst.a",   out_a, 16'h0);
    chk("rst.b",   out_b, 16'h0);
    chk("rst.ctl", {10'd0, out_op, out_dr, out_wr_en, out_setcc}, 16'h0);
    reset_n = 1'b1; drive(1'b0, 16'h0, 16'h0, 16'h0);
    tick();
    chk("rst.rdy", {15'd0, in_ready}, 16'd1);
    chk("rst.vld2", {15'd0, out_valid}, 16'd0);

    // ADD register form, 1-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 16'h1283, 16'h0005, 16'h0007);
    tick();
    drive(1'b0, 16'h0, 16'h0, 16'h0);
    chk_head("add", 16'h0005, 16'h0007, 2'b00, 3'd1, 1'b1, 1'b1);
    tick();
    chk("add.pop", {15'd0, out_valid}, 16'd0);

    // XOR #-1 (NOT) then AND #-16 back to back with push+pop
    drive(1'b1, 16'h927F, 16'h00F0, 16'h1111);
    tick();
    chk_head("xor", 16'h00F0, 16'hFFFF, 2'b10, 3'd1, 1'b1, 1'b1);
    drive(1'b1, 16'h5270, 16'h0F0F, 16'h2222);
    tick();
    chk_head("and", 16'h0F0F, 16'hFFF0, 2'b01, 3'd1, 1'b1, 1'b1);
    // LEA with offset -1: 0x3000 + (-2)
    drive(1'b1, 16'hE3FF, 16'h4444, 16'h5555);
    tick();
    chk_head("lea", 16'h2FFE, 16'h0000, 2'b11, 3'd1, 1'b1, 1'b0);
    // Non-ALU opcode passes SR1, no writeback
    drive(1'b1, 16'h0283, 16'h6666, 16'h7777);
    tick();
    chk_head("oth", 16'h6666, 16'h0000, 2'b11, 3'd1, 1'b0, 1'b0);
    drive(1'b0, 16'h0, 16'h0, 16'h0);
    tick();
    chk("oth.pop", {15'd0, out_valid}, 16'd0);

    // Backpressure and ordering
    out_ready = 1'b0;
    drive(1'b1, 16'h1283, 16'h000A, 16'h000B);
    tick();
    drive(1'b1, 16'h5283, 16'h000C, 16'h000D);
    tick();
    chk("bp.full", {15'd0, in_ready}, 16'd0);
    chk("bp.head", out_a, 16'h000A);
    drive(1'b1, 16'h9283, 16'h00EE, 16'h00EF);
    tick();
    chk("bp.full2", {15'd0, in_ready}, 16'd0);
    chk("bp.head2", out_a, 16'h000A);
    drive(1'b0, 16'h0, 16'h0, 16'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp.rdy", {15'd0, in_ready}, 16'd1);
    chk_head("bp.2nd", 16'h000C, 16'h000D, 2'b01, 3'd1, 1'b1, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp.3rd_dropped", {15'd0, out_valid}, 16'd0);

    // Held bypass on the head
    drive(1'b1, 16'h1283, 16'h0001, 16'h0002);
    tick();
    drive(1'b0, 16'h0, 16'h0, 16'h0);
    chk("hb.pre", out_b, 16'h0002);
    wb_en = 1'b1; wb_reg = 3'd3; wb_data = 16'h1234;
    tick();
    chk("hb.b", out_b, 16'h1234);
    chk("hb.a", out_a, 16'h0001);
    wb_reg = 3'd5; wb_data = 16'hDEAD;
    tick();
    wb_en = 1'b0;
    chk("hb.nomatch.a", out_a, 16'h0001);
    chk("hb.nomatch.b", out_b, 16'h1234);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Capture bypass on SR1
    drive(1'b1, 16'h1283, 16'h1111, 16'h2222);
    wb_en = 1'b1; wb_reg = 3'd2; wb_data = 16'hBEEF;
    tick();
    chk("cb.a", out_a, 16'hBEEF);
    chk("cb.b", out_b, 16'h2222);
    // Immediate form ignores a write to R3; held head (uses R3) picks it up
    drive(1'b1, 16'h12A3, 16'h0100, 16'h0999);
    wb_reg = 3'd3; wb_data = 16'h5555;
    tick();
    drive(1'b0, 16'h0, 16'h0, 16'h0);
    wb_en = 1'b0;
    chk("cb.head_b", out_b, 16'h5555);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_head("imm", 16'h0100, 16'h0003, 2'b00, 3'd1, 1'b1, 1'b1);

    // Fill, then flush while pushing and popping
    drive(1'b1, 16'h1283, 16'h0033, 16'h0044);
    tick();
    chk("fl.full", {15'd0, in_ready}, 16'd0);
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 16'h1283, 16'h0055, 16'h0066);
    tick();
    flush = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 16'h0);
    chk("fl.vld", {15'd0, out_valid}, 16'd0);
    chk("fl.rdy", {15'd0, in_ready}, 16'd1);
    tick();
    chk("fl.vld2", {15'd0, out_valid}, 16'd0);

    // Reset mid-operation drops entries
    out_ready = 1'b0;
    drive(1'b1, 16'h1283, 16'h0077, 16'h0088);
    tick();
    chk("mr.pre", {15'd0, out_valid}, 16'd1);
    drive(1'b0, 16'h0, 16'h0, 16'h0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mr.vld", {15'd0, out_valid}, 16'd0);
    chk("mr.a",   out_a, 16'h0);
    tick();
    chk("mr.rdy", {15'd0, in_ready}, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
